// File: rtl/taitosj_obj_pkg.sv
`default_nettype none
// ============================================================================
// Package     : taitosj_obj_pkg
// Description : Shared definitions for the object pipeline (object bus and
//               object graphics shifter): default pixel phases, fetch FSM
//               state encoding, and a byte bit-reversal helper.
// Revision    : 1.0 - initial release
// ============================================================================
package taitosj_obj_pkg;

    // Default pixel phases (HN[2:0]) for the graphics fetch and shifter load
    localparam int unsigned c_fetch_ph_default = 3;
    localparam int unsigned c_load_ph_default  = 7;

    // Graphics fetch FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        READY = 2'd2
    } obj_fsm_t;

    // Mirror a byte so that bit 0 becomes the leftmost pixel
    function automatic logic [7:0] bitrev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/obj_plane_shreg.sv
`default_nettype none
// ============================================================================
// Module      : obj_plane_shreg
// Description : One bit-plane of the object pixel serialiser. Parallel load
//               with optional horizontal flip, then shifts left with zero
//               fill; the MSB is the current pixel bit.
// Revision    : 1.0 - initial release
// ============================================================================
module obj_plane_shreg
    import taitosj_obj_pkg::*;
(
    input  logic       clkm_48MHZ,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_shift,
    input  logic       i_flip,
    input  logic [7:0] i_data,
    output logic       o_msb
);

    logic [7:0] r_sh;

    // Load has priority; otherwise drain one pixel per shift strobe
    always_ff @(posedge clkm_48MHZ or posedge reset) begin
        if (reset) begin
            r_sh <= 8'h00;
        end else if (i_load) begin
            r_sh <= i_flip ? bitrev8(i_data) : i_data;
        end else if (i_shift) begin
            r_sh <= {r_sh[6:0], 1'b0};
        end
    end

    assign o_msb = r_sh[7];

endmodule
`default_nettype wire

// File: rtl/obj_gfx_shifter.sv
`default_nettype none
// ============================================================================
// Module      : obj_gfx_shifter
// Description : Object graphics fetch and pixel serialiser. Once per 8-pixel
//               slice it latches the object character address, fetches three
//               bit-plane bytes over a req/ack port and shifts 3-bit pixels
//               out on QBUS, one per pixel-clock enable.
// Revision    : 1.0 - initial release
// ============================================================================
module obj_gfx_shifter
    import taitosj_obj_pkg::*;
#(
    parameter int unsigned FETCH_PH = c_fetch_ph_default,
    parameter int unsigned LOAD_PH  = c_load_ph_default,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic              clkm_48MHZ,
    input  logic              reset,
    input  logic              pix_ce,
    input  logic [8:0]        syncbus_HN,
    input  logic [ADDR_W-1:0] OBJ_CHA,
    input  logic              OBJ_CINV,
    input  logic              INRANG,
    output logic              gfx_req,
    output logic [ADDR_W-1:0] gfx_addr,
    input  logic              gfx_ack,
    input  logic [23:0]       gfx_data,
    output logic [2:0]        QBUS,
    output logic              underrun
);

    localparam logic [2:0] c_FETCH = 3'(FETCH_PH);
    localparam logic [2:0] c_LOAD  = 3'(LOAD_PH);

    // A fetch and a load in the same pixel would race on the holding register
    generate
        if (FETCH_PH == LOAD_PH) begin : g_phase_clash
            $error("obj_gfx_shifter: FETCH_PH and LOAD_PH must differ");
        end
    endgenerate

    // ---------------------------------------------------------------- events
    logic w_hbl;
    logic w_fetch_ev;
    logic w_load_ev;
    logic w_shift;
    logic w_unused_hn;

    assign w_hbl       = syncbus_HN[8];
    assign w_fetch_ev  = pix_ce & ~w_hbl & (syncbus_HN[2:0] == c_FETCH);
    assign w_load_ev   = pix_ce & ~w_hbl & (syncbus_HN[2:0] == c_LOAD);
    assign w_shift     = pix_ce & ~w_load_ev;
    assign w_unused_hn = ^syncbus_HN[7:3];

    // ------------------------------------------------------------------- FSM
    obj_fsm_t r_state;
    obj_fsm_t w_state_nxt;
    logic     w_latch;
    logic     w_capture;
    logic     w_clear_hold;
    logic     w_load_hit;
    logic     w_abandon;

    logic [ADDR_W-1:0] r_gfx_addr;
    logic              r_cinv_h;
    logic [23:0]       r_hold;
    logic              r_gen;
    logic              r_req_gen;
    logic              r_hold_gen;
    logic              r_underrun;

    // State register
    always_ff @(posedge clkm_48MHZ or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes; a load always wins over a same-cycle ack
    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_capture    = 1'b0;
        w_clear_hold = 1'b0;
        w_load_hit   = 1'b0;
        w_abandon    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fetch_ev) begin
                    w_latch = 1'b1;
                    if (INRANG) begin
                        w_state_nxt = REQ;
                    end else begin
                        // Out-of-range row: present a blank slice, no bus access
                        w_clear_hold = 1'b1;
                        w_state_nxt  = READY;
                    end
                end
            end
            REQ: begin
                if (w_load_ev) begin
                    w_abandon   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (gfx_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = READY;
                end
            end
            READY: begin
                if (w_load_ev) begin
                    // Data fetched before a later fetch event is stale
                    w_load_hit  = (r_hold_gen == r_gen);
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Address/attribute latch, holding register and generation tagging
    always_ff @(posedge clkm_48MHZ or posedge reset) begin
        if (reset) begin
            r_gfx_addr <= '0;
            r_cinv_h   <= 1'b0;
            r_hold     <= 24'h000000;
            r_gen      <= 1'b0;
            r_req_gen  <= 1'b0;
            r_hold_gen <= 1'b0;
        end else begin
            if (w_fetch_ev) begin
                r_gen <= ~r_gen;
            end
            if (w_latch) begin
                r_gfx_addr <= OBJ_CHA;
                r_cinv_h   <= OBJ_CINV;
                r_req_gen  <= ~r_gen;
            end
            if (w_clear_hold) begin
                r_hold     <= 24'h000000;
                r_hold_gen <= ~r_gen;
            end
            if (w_capture) begin
                r_hold     <= gfx_data;
                r_hold_gen <= r_req_gen;
            end
        end
    end

    // Sticky flag: a load event arrived while the fetch was still outstanding
    always_ff @(posedge clkm_48MHZ or posedge reset) begin
        if (reset) begin
            r_underrun <= 1'b0;
        end else if (w_abandon) begin
            r_underrun <= 1'b1;
        end
    end

    assign gfx_req  = (r_state == REQ);
    assign gfx_addr = r_gfx_addr;
    assign underrun = r_underrun;

    // ------------------------------------------------------------- shifters
    logic [2:0] w_msb;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_plane
            obj_plane_shreg u_shreg (
                .clkm_48MHZ (clkm_48MHZ),
                .reset      (reset),
                .i_load     (w_load_ev),
                .i_shift    (w_shift),
                .i_flip     (r_cinv_h),
                .i_data     (w_load_hit ? r_hold[8*gi +: 8] : 8'h00),
                .o_msb      (w_msb[gi])
            );
        end
    endgenerate

    assign QBUS = w_msb;

endmodule
`default_nettype wire

// File: tb/tb_obj_gfx_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_obj_gfx_shifter
// Description : Self-checking bench for obj_gfx_shifter. A transaction-level
//               model tracks the outstanding fetch and the pixels of the
//               most recent load; scenario tasks compare the DUT against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obj_gfx_shifter;

    logic        clkm_48MHZ = 1'b0;
    logic        reset      = 1'b1;
    logic        pix_ce     = 1'b0;
    logic [8:0]  syncbus_HN = 9'd0;
    logic [10:0] OBJ_CHA    = 11'd0;
    logic        OBJ_CINV   = 1'b0;
    logic        INRANG     = 1'b0;
    logic        gfx_req;
    logic [10:0] gfx_addr;
    logic        gfx_ack    = 1'b0;
    logic [23:0] gfx_data   = 24'd0;
    logic [2:0]  QBUS;
    logic        underrun;

    always #10 clkm_48MHZ = ~clkm_48MHZ;

    obj_gfx_shifter #(.FETCH_PH(3), .LOAD_PH(7), .ADDR_W(11)) dut (
        .clkm_48MHZ (clkm_48MHZ),
        .reset      (reset),
        .pix_ce     (pix_ce),
        .syncbus_HN (syncbus_HN),
        .OBJ_CHA    (OBJ_CHA),
        .OBJ_CINV   (OBJ_CINV),
        .INRANG     (INRANG),
        .gfx_req    (gfx_req),
        .gfx_addr   (gfx_addr),
        .gfx_ack    (gfx_ack),
        .gfx_data   (gfx_data),
        .QBUS       (QBUS),
        .underrun   (underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Pixel timing: pix_ce every 8 clocks, phase advances after each pix_ce
    int       cyc = 0;
    logic [2:0] ph  = 3'd0;
    logic     hbl = 1'b0;

    // Stimulus presented for the next fetch event
    logic [10:0] s_cha   = 11'd0;
    logic        s_cinv  = 1'b0;
    logic        s_rng   = 1'b0;
    logic [23:0] s_data  = 24'd0;
    int          s_dly   = -1;     // clocks from request to ack; -1 = never
    logic        force_ack = 1'b0;

    // Reference model: one outstanding fetch, pixels of the last load
    int          m_gen, m_tag, m_wait, m_idx;
    bit          m_busy, m_pend, m_got, m_cinv, m_under;
    logic [23:0] m_data;
    logic [10:0] m_addr;
    logic [2:0]  m_px [8];

    // Pixel k of a slice: one bit from each plane, leftmost = bit 7 unless flipped
    function automatic logic [2:0] pix_of(input logic [23:0] d, input logic inv, input int k);
        int b;
        b = inv ? k : 7 - k;
        return {d[16+b], d[8+b], d[b]};
    endfunction

    function automatic logic [2:0] exp_q();
        return (m_idx < 8) ? m_px[m_idx] : 3'd0;
    endfunction

    task automatic model_clear();
        m_busy = 0; m_pend = 0; m_got = 0; m_under = 0; m_cinv = 0;
        m_idx = 8; m_gen = 0; m_tag = 0; m_wait = 0;
        m_addr = 11'd0; m_data = 24'd0;
    endtask

    // Drive one clock of stimulus, advance the model over that edge, then
    // return 1 ns after the edge with the DUT outputs settled.
    task automatic step();
        logic fe, le, ak;
        pix_ce     = (cyc % 8 == 0);
        syncbus_HN = {hbl, 5'd0, ph};
        OBJ_CHA    = s_cha;
        OBJ_CINV   = s_cinv;
        INRANG     = s_rng;
        fe = pix_ce && !hbl && (ph == 3'd3);
        le = pix_ce && !hbl && (ph == 3'd7);
        if (m_pend) m_wait++;
        ak = force_ack || (m_pend && s_dly >= 0 && m_wait == s_dly);
        gfx_ack  = ak;
        gfx_data = ak ? s_data : 24'($urandom);
        if (reset) begin
            model_clear();
        end else if (le) begin
            for (int k = 0; k < 8; k++)
                m_px[k] = (m_busy && m_got && m_tag == m_gen) ? pix_of(m_data, m_cinv, k) : 3'd0;
            m_idx = 0;
            if (m_pend) m_under = 1;
            m_busy = 0; m_pend = 0; m_got = 0;
        end else begin
            if (pix_ce && m_idx < 8) m_idx++;
            if (fe) begin
                m_gen++;
                if (!m_busy) begin
                    m_busy = 1; m_tag = m_gen; m_cinv = s_cinv; m_addr = s_cha; m_wait = 0;
                    if (s_rng) begin
                        m_pend = 1; m_got = 0;
                    end else begin
                        m_pend = 0; m_got = 1; m_data = 24'd0;
                    end
                end
            end else if (ak && m_pend) begin
                m_pend = 0; m_got = 1; m_data = s_data;
            end
        end
        @(posedge clkm_48MHZ);
        #1;
        if (pix_ce) ph = ph + 3'd1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        repeat (3) step();
        n_cmp++; if (QBUS !== 3'd0)      begin n_bad++; $display("FAIL reset_qbus: got %0d want 0", QBUS); end
        n_cmp++; if (gfx_req !== 1'b0)   begin n_bad++; $display("FAIL reset_req: got %0b want 0", gfx_req); end
        n_cmp++; if (gfx_addr !== 11'd0) begin n_bad++; $display("FAIL reset_addr: got %0h want 0", gfx_addr); end
        n_cmp++; if (underrun !== 1'b0)  begin n_bad++; $display("FAIL reset_underrun: got %0b want 0", underrun); end
        reset = 1'b0;
        cyc = 0;
        ph  = 3'd0;
    endtask

    // Fixed slice data, optionally flipped; pixels checked against hand-derived columns
    task automatic test_slice(input logic inv, input logic [2:0] want [8]);
        logic [2:0] got [8];
        s_cha = 11'h155; s_data = 24'hF00F81; s_cinv = inv; s_rng = 1'b1; s_dly = 4;
        for (int c = 0; c < 128; c++) begin
            if (c == 64) s_rng = 1'b0;
            step();
            n_cmp++; if (QBUS !== exp_q())    begin n_bad++; $display("FAIL slice_qbus c=%0d: got %0d want %0d", c, QBUS, exp_q()); end
            n_cmp++; if (gfx_req !== m_pend) begin n_bad++; $display("FAIL slice_req c=%0d: got %0b want %0b", c, gfx_req, m_pend); end
            if (c == 24) begin
                n_cmp++; if (gfx_addr !== 11'h155) begin n_bad++; $display("FAIL slice_addr: got %0h want 155", gfx_addr); end
                n_cmp++; if (gfx_req !== 1'b1)     begin n_bad++; $display("FAIL slice_req_rise: got %0b want 1", gfx_req); end
            end
            if (c >= 56 && (c - 56) % 8 == 0 && c < 120) got[(c - 56) / 8] = QBUS;
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (got[k] !== want[k]) begin n_bad++; $display("FAIL slice_pixel%0d inv=%0b: got %0d want %0d", k, inv, got[k], want[k]); end
        end
        n_cmp++; if (gfx_addr !== 11'h155) begin n_bad++; $display("FAIL slice_addr_hold: got %0h want 155", gfx_addr); end
    endtask

    task automatic test_normal();
        logic [2:0] want [8];
        want = '{3'd5, 3'd4, 3'd4, 3'd4, 3'd2, 3'd2, 3'd2, 3'd3};
        test_slice(1'b0, want);
    endtask

    task automatic test_cinv();
        logic [2:0] want [8];
        want = '{3'd3, 3'd2, 3'd2, 3'd2, 3'd4, 3'd4, 3'd4, 3'd5};
        test_slice(1'b1, want);
    endtask

    task automatic test_out_of_range();
        s_rng = 1'b0; s_cinv = 1'($urandom); s_data = 24'($urandom); s_dly = 2;
        for (int c = 0; c < 128; c++) begin
            step();
            n_cmp++; if (gfx_req !== 1'b0) begin n_bad++; $display("FAIL oor_req c=%0d: got %0b want 0", c, gfx_req); end
            n_cmp++; if (QBUS !== 3'd0)    begin n_bad++; $display("FAIL oor_qbus c=%0d: got %0d want 0", c, QBUS); end
        end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL oor_underrun: got %0b want 0", underrun); end
    endtask

    task automatic test_underrun();
        s_rng = 1'b1; s_cha = 11'h2A3; s_data = 24'hFFFFFF; s_dly = -1;
        for (int c = 0; c < 128; c++) begin
            force_ack = (c == 58);
            if (c == 60) s_rng = 1'b0;
            step();
            force_ack = 1'b0;
            n_cmp++; if (QBUS !== exp_q())    begin n_bad++; $display("FAIL ur_qbus c=%0d: got %0d want %0d", c, QBUS, exp_q()); end
            n_cmp++; if (gfx_req !== m_pend) begin n_bad++; $display("FAIL ur_req c=%0d: got %0b want %0b", c, gfx_req, m_pend); end
            if (c >= 56 && c < 120) begin
                n_cmp++; if (QBUS !== 3'd0)     begin n_bad++; $display("FAIL ur_blank c=%0d: got %0d want 0", c, QBUS); end
                n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL ur_flag c=%0d: got %0b want 1", c, underrun); end
                n_cmp++; if (gfx_req !== 1'b0)  begin n_bad++; $display("FAIL ur_req_low c=%0d: got %0b want 0", c, gfx_req); end
            end
        end
        n_cmp++; if (gfx_addr !== 11'h2A3) begin n_bad++; $display("FAIL ur_addr: got %0h want 2a3", gfx_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        s_rng = 1'b1; s_cha = 11'($urandom); s_data = 24'($urandom); s_dly = -1;
        for (int c = 0; c < 192; c++) begin
            force_ack = (c == 36);
            if (c == 64) begin s_dly = $urandom_range(1, 20); s_cinv = 1'($urandom); end
            step();
            force_ack = 1'b0;
            if (c == 30) begin
                n_cmp++; if (gfx_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre_req: got %0b want 1", gfx_req); end
                #4 reset = 1'b1;
                #1;
                model_clear();
                n_cmp++; if (gfx_req !== 1'b0)  begin n_bad++; $display("FAIL rst_async_req: got %0b want 0", gfx_req); end
                n_cmp++; if (QBUS !== 3'd0)     begin n_bad++; $display("FAIL rst_async_qbus: got %0d want 0", QBUS); end
                n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rst_async_underrun: got %0b want 0", underrun); end
            end
            if (c == 34) reset = 1'b0;
            n_cmp++; if (QBUS !== exp_q())    begin n_bad++; $display("FAIL rst_qbus c=%0d: got %0d want %0d", c, QBUS, exp_q()); end
            n_cmp++; if (gfx_req !== m_pend) begin n_bad++; $display("FAIL rst_req c=%0d: got %0b want %0b", c, gfx_req, m_pend); end
            n_cmp++; if (gfx_addr !== m_addr) begin n_bad++; $display("FAIL rst_addr c=%0d: got %0h want %0h", c, gfx_addr, m_addr); end
        end
    endtask

    task automatic test_hbl();
        s_rng = 1'b1; s_cha = 11'($urandom); s_data = 24'($urandom) | 24'h010101; s_cinv = 1'b0; s_dly = 3;
        for (int c = 0; c < 320; c++) begin
            if (c == 64) hbl = 1'b1;
            step();
            n_cmp++; if (QBUS !== exp_q()) begin n_bad++; $display("FAIL hbl_qbus c=%0d: got %0d want %0d", c, QBUS, exp_q()); end
            if (c >= 64) begin
                n_cmp++; if (gfx_req !== 1'b0) begin n_bad++; $display("FAIL hbl_req c=%0d: got %0b want 0", c, gfx_req); end
            end
            if (c >= 120) begin
                n_cmp++; if (QBUS !== 3'd0) begin n_bad++; $display("FAIL hbl_drain c=%0d: got %0d want 0", c, QBUS); end
            end
        end
        hbl = 1'b0;
    endtask

    task automatic test_hbl_stale();
        s_rng = 1'b1; s_cha = 11'($urandom); s_data = 24'hFFFFFF; s_cinv = 1'b0; s_dly = 10;
        for (int c = 0; c < 384; c++) begin
            if (c == 26)  hbl = 1'b1;
            if (c == 100) begin s_data = 24'($urandom); s_cha = 11'($urandom); end
            if (c == 192) hbl = 1'b0;
            step();
            n_cmp++; if (QBUS !== exp_q())     begin n_bad++; $display("FAIL stale_qbus c=%0d: got %0d want %0d", c, QBUS, exp_q()); end
            n_cmp++; if (gfx_req !== m_pend)  begin n_bad++; $display("FAIL stale_req c=%0d: got %0b want %0b", c, gfx_req, m_pend); end
            n_cmp++; if (gfx_addr !== m_addr) begin n_bad++; $display("FAIL stale_addr c=%0d: got %0h want %0h", c, gfx_addr, m_addr); end
            if (c == 216) begin
                n_cmp++; if (gfx_req !== 1'b0) begin n_bad++; $display("FAIL stale_no_fetch: got %0b want 0", gfx_req); end
            end
            if (c >= 248 && c < 312) begin
                n_cmp++; if (QBUS !== 3'd0) begin n_bad++; $display("FAIL stale_drop c=%0d: got %0d want 0", c, QBUS); end
            end
            if (c == 280) begin
                n_cmp++; if (gfx_req !== 1'b1) begin n_bad++; $display("FAIL stale_refetch: got %0b want 1", gfx_req); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int dly_tab [3];
        dly_tab = '{31, 32, 33};
        for (int b = 0; b < 24; b++) begin
            s_rng  = (b < 3) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            s_cinv = 1'($urandom);
            s_cha  = 11'($urandom);
            s_data = 24'($urandom);
            s_dly  = (b < 3) ? dly_tab[b] : $urandom_range(1, 34);
            for (int c = 0; c < 64; c++) begin
                step();
                n_cmp++; if (QBUS !== exp_q())     begin n_bad++; $display("FAIL b2b_qbus b=%0d c=%0d: got %0d want %0d", b, c, QBUS, exp_q()); end
                n_cmp++; if (gfx_req !== m_pend)  begin n_bad++; $display("FAIL b2b_req b=%0d c=%0d: got %0b want %0b", b, c, gfx_req, m_pend); end
                n_cmp++; if (gfx_addr !== m_addr) begin n_bad++; $display("FAIL b2b_addr b=%0d c=%0d: got %0h want %0h", b, c, gfx_addr, m_addr); end
                n_cmp++; if (underrun !== m_under) begin n_bad++; $display("FAIL b2b_underrun b=%0d c=%0d: got %0b want %0b", b, c, underrun, m_under); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_cinv();
        test_out_of_range();
        test_underrun();
        test_reset_mid_fetch();
        test_hbl();
        test_hbl_stale();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
